// File: rtl/r16_reorder_rom_ctrl_if.sv
// Request/grant, ROM address and tag-pipeline bundle for the radix-16 reorder ROM scheduler.
// The controller uses the slave modport; the requesters/downstream side uses master.
interface r16_reorder_rom_ctrl_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  fwd_req;
    logic                  inv_req;
    logic                  stall;
    logic                  fwd_gnt;
    logic                  inv_gnt;
    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic                  rom_sel;
    logic                  data_valid;
    logic                  data_sel;
    logic                  data_last;
    logic                  frame_done;
    logic                  busy;

    modport master (
        output fwd_req, inv_req, stall,
        input  fwd_gnt, inv_gnt, rom_en, rom_addr, rom_sel,
        input  data_valid, data_sel, data_last, frame_done, busy
    );

    modport slave (
        input  fwd_req, inv_req, stall,
        output fwd_gnt, inv_gnt, rom_en, rom_addr, rom_sel,
        output data_valid, data_sel, data_last, frame_done, busy
    );
endinterface

// File: rtl/r16_reorder_rom_ctrl.sv
// Arbitrates the forward/inverse FFT output stages onto the shared reorder ROM bank,
// streams one frame of addresses per grant and keeps a valid/select/last tag aligned with ROM data.
module r16_reorder_rom_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int ROM_LAT    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    r16_reorder_rom_ctrl_if.slave   bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [2:0]            DRAIN_INIT = 3'(ROM_LAT - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            drain_cnt;
    logic                  owner;
    logic                  last_owner;
    logic                  first;
    logic                  winner;
    logic                  issue;
    logic                  at_last;
    logic [ROM_LAT-1:0]    valid_pipe;
    logic [ROM_LAT-1:0]    sel_pipe;
    logic [ROM_LAT-1:0]    last_pipe;

    assign issue   = (state == RUN) && !bus.stall;
    assign at_last = (addr == LAST_ADDR);

    // On a tie the side that did not own the previous frame wins.
    always_comb begin
        winner = bus.inv_req;
        if (bus.fwd_req && bus.inv_req) begin
            winner = ~last_owner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            drain_cnt  <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            first      <= 1'b0;
        end else begin
            first <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.fwd_req || bus.inv_req) begin
                        owner <= winner;
                        addr  <= '0;
                        first <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (at_last) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_INIT;
                        end else begin
                            addr <= addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt != 3'd0) begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end else begin
                        state      <= IDLE;
                        last_owner <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running tag shift register; stall deliberately does not freeze it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_pipe <= '0;
            sel_pipe   <= '0;
            last_pipe  <= '0;
        end else begin
            valid_pipe <= ROM_LAT'({valid_pipe, issue});
            sel_pipe   <= ROM_LAT'({sel_pipe, owner});
            last_pipe  <= ROM_LAT'({last_pipe, issue & at_last});
        end
    end

    assign bus.fwd_gnt    = first & ~owner;
    assign bus.inv_gnt    = first & owner;
    assign bus.rom_en     = issue;
    assign bus.rom_addr   = addr;
    assign bus.rom_sel    = owner;
    assign bus.data_valid = valid_pipe[ROM_LAT-1];
    assign bus.data_sel   = sel_pipe[ROM_LAT-1];
    assign bus.data_last  = last_pipe[ROM_LAT-1];
    assign bus.frame_done = valid_pipe[ROM_LAT-1] & last_pipe[ROM_LAT-1];
    assign bus.busy       = (state != IDLE);

endmodule

// File: doc/r16_reorder_rom_ctrl.md
# r16_reorder_rom_ctrl

Scheduler for the radix-16 16384-point FFT reorder ROM pipeline. It arbitrates between the forward-FFT output stage and the inverse-FFT output stage, which share one reorder/ireorder ROM bank and its output pipeline register. For the granted requester it streams one full frame of ROM addresses. A valid/select/last tag pipeline stays cycle-aligned with the registered ROM outputs.

## Interface
Parameters:
- ADDR_WIDTH, 10, ROM address width.
- DEPTH, 1024, entries per frame (16384/16); the last address issued is DEPTH-1.
- ROM_LAT, 2, cycles from rom_en to data at the pipe-register outputs (1 ROM read plus 1 pipe register); legal range 1..4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- fwd_req  in  1  forward-FFT requests a reorder frame. Level signal; held until fwd_gnt.
- inv_req  in  1  inverse-FFT requests an ireorder frame. Level signal; held until inv_gnt.
- stall  in  1  downstream back-pressure; suppresses address issue for this cycle.
- fwd_gnt  out  1  one-cycle grant pulse to the forward requester.
- inv_gnt  out  1  one-cycle grant pulse to the inverse requester.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_WIDTH  ROM read address.
- rom_sel  out  1  selects the ROM table: 0 = reorder, 1 = ireorder.
- data_valid  out  1  pipe-register outputs hold valid data this cycle.
- data_sel  out  1  owner of the data currently on the pipe outputs (0 = fwd, 1 = inv).
- data_last  out  1  the current data word is the final word of the frame.
- frame_done  out  1  one-cycle pulse; equal to data_valid & data_last.
- busy  out  1  the FSM is not in IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE, no request pending: stay in IDLE.
- IDLE, request pending: pick the winner, register its select into owner, set addr=0 and go to RUN.
  - Only one request high: that requester wins.
  - Both requests high: the requester that is not last_owner wins (round robin).
  - last_owner resets to 1, so fwd wins the first tie.
- RUN, stall=0: rom_en=1, rom_addr=addr, rom_sel=owner.
  - addr<DEPTH-1: addr increments.
  - addr==DEPTH-1: go to DRAIN and load drain_cnt=ROM_LAT-1.
- RUN, stall=1: rom_en=0; addr and state hold.
- DRAIN: rom_en=0 and stall is ignored.
  - drain_cnt>0: decrement drain_cnt.
  - drain_cnt==0: go to IDLE and set last_owner=owner.
- Grant: fwd_gnt or inv_gnt is high in the first RUN cycle of the frame only, regardless of stall.
- Tag pipeline: a ROM_LAT-deep shift register with no enable. It shifts {rom_en, rom_sel, rom_en & (addr==DEPTH-1)} every cycle. Its outputs are data_valid, data_sel and data_last. stall does not freeze it.
- Requests are sampled only in IDLE. A requester must not drop req before its grant; if it does, behaviour is unspecified.
- Address counter: ADDR_WIDTH bits and never wraps. The frame ends at DEPTH-1 even when DEPTH < 2^ADDR_WIDTH.
- Reset values: state=IDLE, addr=0, drain_cnt=0, owner=0, last_owner=1, tag pipeline all 0.
- Output values during reset: all outputs are 0.
- Reset mid-frame: the frame is aborted and the tag pipeline is cleared. No data_valid or frame_done appears after reset is released.

## Timing
- Request to grant:
  - Edge t: req is sampled high in IDLE.
  - Cycle t+1: grant pulse, busy=1, rom_en=1 with addr 0 (if stall=0).
- An unstalled frame occupies RUN for exactly DEPTH cycles. Each stalled cycle adds one cycle.
- The data for a read issued in cycle c appears at the pipe outputs with data_valid=1 in cycle c+ROM_LAT.
- The last rom_en is in cycle L. data_last and frame_done are high in cycle L+ROM_LAT, which is the final DRAIN cycle.
- IDLE follows in cycle L+ROM_LAT+1.
- Back-to-back frames: the next grant is at the earliest in cycle L+ROM_LAT+2, leaving one IDLE cycle.
- busy covers every cycle from the grant through the frame_done cycle inclusive.

## Test plan
- Single forward frame, defaults, no stall:
  - fwd_req rises at cycle 5.
  - fwd_gnt at cycle 6; rom_addr 0..1023 on cycles 6..1029 with rom_sel=0.
  - data_valid on cycles 8..1031; frame_done at cycle 1031; busy falls at cycle 1032.
- Tie and round robin with fwd_req and inv_req both held high:
  - Grant order is fwd, inv, fwd.
  - Consecutive grants are 1027 cycles apart (1026-cycle frame plus 1 IDLE cycle).
  - data_sel matches the owner of each frame.
- Stall:
  - stall=1 for 3 cycles while rom_addr=100.
  - Address 100 is issued exactly once, and rom_addr 101 follows the stall.
  - data_valid shows a matching 3-cycle gap.
  - frame_done is delayed by 3 cycles.
- Stall in the grant cycle:
  - inv_gnt still pulses for exactly 1 cycle.
  - Address 0 is issued on the first unstalled cycle.
- Reset mid-frame:
  - rst_n drops at rom_addr=500.
  - All outputs go to 0 immediately.
  - After release with no requests, data_valid stays 0 for 10 cycles.
- ROM_LAT=1 and DEPTH=16:
  - frame_done comes exactly 1 cycle after the rom_en for address 15.
  - Exactly 16 data_valid cycles per frame.
